ex_stage_mod: RTL and testbench
===============================

Name: ex_stage_mod

Overview:
- Execute stage of the RSA decryption ASIP. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Performs operand forwarding from MEM and WB, and operand-B selection.
- Executes either a single-cycle add or an iterative 32-step restoring modulo (A mod B) for RSA reduction.
- Registers results into the EX/MEM boundary. Raises stall toward upstream stages while a modulo is in progress.

Parameters:
N, 32, datapath width; also the modulo iteration count.

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
valid_in  in  1  ID/EX holds a real instruction
rda_ex  in  N  register-file value for A
rdb_ex  in  N  register-file value for B
extended_ex  in  N  sign/zero-extended immediate
ra_ex  in  5  source register A index
rb_ex  in  5  source register B index
rw_ex  in  5  destination register index
wr_en_ex  in  1  register write enable
opb_selector_ex  in  1  0: B = forwarded rdb; 1: B = extended_ex
alu_func_ex  in  1  0: add; 1: A mod B
wd_selector_ex  in  1  write-back select, passed through
wm_ex  in  1  memory write, passed through
rw_mem  in  5  MEM-stage destination register
wr_en_mem  in  1  MEM-stage write enable
result_mem  in  N  MEM-stage result
rw_wb  in  5  WB-stage destination register
wr_en_wb  in  1  WB-stage write enable
result_wb  in  N  WB-stage write data
stall  out  1  hold PC, IF/ID and ID/EX
valid_out  out  1  EX/MEM holds a real instruction
alu_result  out  N  add sum or remainder
store_data  out  N  forwarded B-register value, for stores
rw_out  out  5  destination register to EX/MEM
wr_en_out  out  1  write enable to EX/MEM
wd_selector_out  out  1  passed to EX/MEM
wm_out  out  1  passed to EX/MEM
div_zero  out  1  modulo attempted with B = 0

Behaviour:
Forwarding (combinational, per operand):
- Priority order: MEM match first, then WB match, else the register-file value.
- A match requires the stage's write enable = 1, equal register index, and index != 0.
- Register 0 is never forwarded.

Operand B and arithmetic:
- B = extended_ex if opb_selector_ex = 1, else the forwarded rdb.
- Add is modulo 2^N; carry is discarded.

Reset:
- When reset = 1 at a clock edge, every output register clears to 0 and the FSM goes to IDLE.
- An in-flight modulo is aborted and its result is never emitted.
- stall = 0 while in IDLE after reset.

FSM states: IDLE, BUSY, DONE.

IDLE, valid_in = 0:
- Bubble: valid_out, wr_en_out and wm_out are 0 at the next edge.

IDLE, valid_in = 1, alu_func_ex = 0:
- Register add result and control fields. Latency 1 cycle. stall = 0.

IDLE, valid_in = 1, alu_func_ex = 1, B = 0:
- One-cycle result: alu_result = A, div_zero = 1. stall = 0.

IDLE, valid_in = 1, alu_func_ex = 1, B != 0:
- stall = 1 combinationally in that cycle.
- Capture forwarded A, B and the control fields into internal registers. Later changes on the forwarding inputs have no effect.
- Load remainder = 0, count = N, then go to BUSY.
- Emit a bubble at this edge.

BUSY:
- stall = 1.
- Each cycle: remainder = {remainder, A msb}; if remainder >= B, subtract B; shift A left; decrement count.
- When count reaches 1, the edge moves the FSM to DONE.
- A bubble is emitted every BUSY cycle.

DONE:
- stall = 0.
- Register the remainder and the captured control fields; valid_out = 1; div_zero = 0; go to IDLE.
- The ID/EX contents presented during DONE are the same held modulo instruction and are ignored, never re-executed.

Modulo timing:
- stall is high for N+1 consecutive cycles: the accept cycle plus N BUSY cycles.
- The result is visible N+2 cycles after the accept cycle.

Other rules:
- Every valid output clears div_zero to 0 except a modulo with B = 0.
- store_data always carries the forwarded B-register value (rdb path), independent of opb_selector_ex.
- alu_result has width N; the remainder is always < B.

Test Plan:
1. Forwarding priority: ra_ex=5, rda_ex=1, rw_mem=5/wr_en_mem=1/result_mem=10, rw_wb=5/result_wb=20, B=extended_ex=3, add -> alu_result=13 next cycle.
2. Forwarding disabled: same as 1 with ra_ex=0, rda_ex=0 -> alu_result=3; with wr_en_mem=0 and WB matching -> alu_result=23.
3. Modulo: A=100, B=7 -> stall high 33 cycles, alu_result=2, valid_out=1 in cycle 34; bubbles with wr_en_out=0 meanwhile.
4. Modulo wide operands: A=0xFFFFFFFF, B=0x00010001 -> remainder 0. A=123456789, B=1000 -> remainder 789. A=5, B=9 -> remainder 5.
5. Divide by zero: A=42, B=0, alu_func=1 -> no stall, alu_result=42, div_zero=1 next cycle; a following add clears div_zero.
6. Reset mid-modulo: assert reset in BUSY cycle 10 -> all outputs 0, stall=0 next cycle; a subsequent add completes normally in 1 cycle.

Source files
------------

// File: rtl/ex_stage_mod.sv
// Execute stage: MEM/WB operand forwarding, single-cycle add, and a 32-step restoring A mod B.
// Add and mod-by-zero take 1 cycle; a real modulo holds stall for N+1 cycles and emits after N+2 edges.
module ex_stage_mod #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [N-1:0] rda_ex,
  input  logic [N-1:0] rdb_ex,
  input  logic [N-1:0] extended_ex,
  input  logic [4:0]   ra_ex,
  input  logic [4:0]   rb_ex,
  input  logic [4:0]   rw_ex,
  input  logic         wr_en_ex,
  input  logic         opb_selector_ex,
  input  logic         alu_func_ex,
  input  logic         wd_selector_ex,
  input  logic         wm_ex,
  input  logic [4:0]   rw_mem,
  input  logic         wr_en_mem,
  input  logic [N-1:0] result_mem,
  input  logic [4:0]   rw_wb,
  input  logic         wr_en_wb,
  input  logic [N-1:0] result_wb,
  output logic         stall,
  output logic         valid_out,
  output logic [N-1:0] alu_result,
  output logic [N-1:0] store_data,
  output logic [4:0]   rw_out,
  output logic         wr_en_out,
  output logic         wd_selector_out,
  output logic         wm_out,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;

  logic [N-1:0]   w_fwd_a;
  logic [N-1:0]   w_fwd_b;
  logic [N-1:0]   w_opb;
  logic [N-1:0]   w_sum;
  logic           w_mod_start;

  // Modulo working set, frozen at accept so later forwarding changes are ignored
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_rem;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_sd;
  logic [4:0]     r_rw;
  logic           r_wr_en;
  logic           r_wds;
  logic           r_wm;

  logic [N:0]     w_trial;
  logic [N-1:0]   w_diff;
  logic           w_ge;
  logic [N-1:0]   w_rem_next;

  // MEM has priority over WB; register 0 is never forwarded
  always_comb begin
    w_fwd_a = rda_ex;
    if (wr_en_mem && (rw_mem == ra_ex) && (ra_ex != 5'd0))
      w_fwd_a = result_mem;
    else if (wr_en_wb && (rw_wb == ra_ex) && (ra_ex != 5'd0))
      w_fwd_a = result_wb;
  end

  always_comb begin
    w_fwd_b = rdb_ex;
    if (wr_en_mem && (rw_mem == rb_ex) && (rb_ex != 5'd0))
      w_fwd_b = result_mem;
    else if (wr_en_wb && (rw_wb == rb_ex) && (rb_ex != 5'd0))
      w_fwd_b = result_wb;
  end

  assign w_opb       = opb_selector_ex ? extended_ex : w_fwd_b;
  assign w_sum       = w_fwd_a + w_opb;
  assign w_mod_start = (r_state == S_IDLE) && valid_in && alu_func_ex && (w_opb != '0);

  // One restoring step; the difference fits in N bits because the result is always < B
  assign w_trial    = {r_rem, r_a[N-1]};
  assign w_ge       = (w_trial >= {1'b0, r_b});
  assign w_diff     = w_trial[N-1:0] - r_b;
  assign w_rem_next = w_ge ? w_diff : w_trial[N-1:0];

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mod_start) w_next = S_BUSY;
      S_BUSY:  if (r_count == CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_mod_start;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a             <= '0;
      r_b             <= '0;
      r_rem           <= '0;
      r_count         <= '0;
      r_sd            <= '0;
      r_rw            <= '0;
      r_wr_en         <= 1'b0;
      r_wds           <= 1'b0;
      r_wm            <= 1'b0;
      valid_out       <= 1'b0;
      alu_result      <= '0;
      store_data      <= '0;
      rw_out          <= '0;
      wr_en_out       <= 1'b0;
      wd_selector_out <= 1'b0;
      wm_out          <= 1'b0;
      div_zero        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in && !w_mod_start) begin
            valid_out       <= 1'b1;
            alu_result      <= alu_func_ex ? w_fwd_a : w_sum;
            store_data      <= w_fwd_b;
            rw_out          <= rw_ex;
            wr_en_out       <= wr_en_ex;
            wd_selector_out <= wd_selector_ex;
            wm_out          <= wm_ex;
            div_zero        <= alu_func_ex;
          end else begin
            valid_out <= 1'b0;
            wr_en_out <= 1'b0;
            wm_out    <= 1'b0;
            div_zero  <= 1'b0;
            if (w_mod_start) begin
              r_a     <= w_fwd_a;
              r_b     <= w_opb;
              r_rem   <= '0;
              r_count <= CW'(N);
              r_sd    <= w_fwd_b;
              r_rw    <= rw_ex;
              r_wr_en <= wr_en_ex;
              r_wds   <= wd_selector_ex;
              r_wm    <= wm_ex;
            end
          end
        end
        S_BUSY: begin
          r_rem     <= w_rem_next;
          r_a       <= {r_a[N-2:0], 1'b0};
          r_count   <= r_count - CW'(1);
          valid_out <= 1'b0;
          wr_en_out <= 1'b0;
          wm_out    <= 1'b0;
          div_zero  <= 1'b0;
        end
        S_DONE: begin
          valid_out       <= 1'b1;
          alu_result      <= r_rem;
          store_data      <= r_sd;
          rw_out          <= r_rw;
          wr_en_out       <= r_wr_en;
          wd_selector_out <= r_wds;
          wm_out          <= r_wm;
          div_zero        <= 1'b0;
        end
        default: begin
          valid_out <= 1'b0;
          wr_en_out <= 1'b0;
          wm_out    <= 1'b0;
          div_zero  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mod.sv
// Scoreboarded bench for ex_stage_mod: directed forwarding/modulo/reset cases plus random traffic.
module tb_ex_stage_mod;
  localparam int N = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [N-1:0]  rda_ex, rdb_ex, extended_ex;
  logic [4:0]    ra_ex, rb_ex, rw_ex;
  logic          wr_en_ex, opb_selector_ex, alu_func_ex, wd_selector_ex, wm_ex;
  logic [4:0]    rw_mem, rw_wb;
  logic          wr_en_mem, wr_en_wb;
  logic [N-1:0]  result_mem, result_wb;
  logic          stall, valid_out, wr_en_out, wd_selector_out, wm_out, div_zero;
  logic [N-1:0]  alu_result, store_data;
  logic [4:0]    rw_out;

  ex_stage_mod #(.N(N)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .rda_ex(rda_ex), .rdb_ex(rdb_ex), .extended_ex(extended_ex),
    .ra_ex(ra_ex), .rb_ex(rb_ex), .rw_ex(rw_ex), .wr_en_ex(wr_en_ex),
    .opb_selector_ex(opb_selector_ex), .alu_func_ex(alu_func_ex),
    .wd_selector_ex(wd_selector_ex), .wm_ex(wm_ex),
    .rw_mem(rw_mem), .wr_en_mem(wr_en_mem), .result_mem(result_mem),
    .rw_wb(rw_wb), .wr_en_wb(wr_en_wb), .result_wb(result_wb),
    .stall(stall), .valid_out(valid_out), .alu_result(alu_result),
    .store_data(store_data), .rw_out(rw_out), .wr_en_out(wr_en_out),
    .wd_selector_out(wd_selector_out), .wm_out(wm_out), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] sd;
    logic [4:0]   rw;
    logic         wren;
    logic         wds;
    logic         wm;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Forwarding rule: MEM beats WB, index 0 is never forwarded
  function automatic logic [N-1:0] fwd(input logic [4:0] idx, input logic [N-1:0] rf);
    if (idx != 5'd0 && wr_en_mem && rw_mem == idx) return result_mem;
    if (idx != 5'd0 && wr_en_wb && rw_wb == idx) return result_wb;
    return rf;
  endfunction

  // Monitor: every valid output pops one expected entry; bubbles must not write
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      if (valid_out === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got valid_out=1, expected no pending result (cycle %0d)", cyc);
        end else begin
          m = q.pop_front();
          chk("alu_result", alu_result, m.res);
          chk("store_data", store_data, m.sd);
          chk("rw_out", N'(rw_out), N'(m.rw));
          chk("wr_en_out", N'(wr_en_out), N'(m.wren));
          chk("wd_selector_out", N'(wd_selector_out), N'(m.wds));
          chk("wm_out", N'(wm_out), N'(m.wm));
          chk("div_zero", N'(div_zero), N'(m.dz));
          chk("latency_cycle", N'(cyc), N'(m.cyc));
        end
      end else begin
        chk("bubble_valid", N'(valid_out), '0);
        chk("bubble_wr_en", N'(wr_en_out), '0);
        chk("bubble_wm", N'(wm_out), '0);
      end
    end
  end

  task automatic clr_inputs();
    valid_in = 0; rda_ex = 0; rdb_ex = 0; extended_ex = 0;
    ra_ex = 0; rb_ex = 0; rw_ex = 0; wr_en_ex = 0; opb_selector_ex = 0;
    alu_func_ex = 0; wd_selector_ex = 0; wm_ex = 0;
    rw_mem = 0; wr_en_mem = 0; result_mem = 0;
    rw_wb = 0; wr_en_wb = 0; result_wb = 0;
  endtask

  task automatic scramble_fwd();
    rw_mem = 5'($urandom_range(0, 7)); wr_en_mem = 1'($urandom);
    result_mem = $urandom;
    rw_wb = 5'($urandom_range(0, 7)); wr_en_wb = 1'($urandom);
    result_wb = $urandom;
  endtask

  // Present the current inputs as the ID/EX instruction, held while stall is high
  task automatic send(input bit use_k, input logic [N-1:0] k);
    logic [N-1:0] a, breg, b;
    exp_t x;
    int   n, n_exp;
    bit   s;
    a = fwd(ra_ex, rda_ex);
    breg = fwd(rb_ex, rdb_ex);
    b = opb_selector_ex ? extended_ex : breg;
    x.sd = breg; x.rw = rw_ex; x.wren = wr_en_ex; x.wds = wd_selector_ex;
    x.wm = wm_ex; x.dz = 1'b0; n_exp = 0;
    if (!alu_func_ex) begin
      x.res = a + b; x.cyc = cyc + 1;
    end else if (b == 0) begin
      x.res = a; x.dz = 1'b1; x.cyc = cyc + 1;
    end else begin
      x.res = a % b; x.cyc = cyc + N + 2; n_exp = N + 1;
    end
    if (use_k) x.res = k;
    if (valid_in) q.push_back(x);
    else n_exp = 0;
    n = 0;
    forever begin
      @(negedge clock);
      s = stall;
      if (s) n++;
      @(posedge clock);
      #1;
      if (!s || n > 200) break;
      scramble_fwd();
    end
    chk("stall_cycles", N'(n), N'(n_exp));
  endtask

  initial begin
    clr_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid_out", N'(valid_out), '0);
    chk("rst_alu_result", alu_result, '0);
    chk("rst_div_zero", N'(div_zero), '0);
    chk("rst_stall", N'(stall), '0);
    reset = 0;

    // Forwarding priority: MEM beats WB
    valid_in = 1; ra_ex = 5; rda_ex = 1; rw_mem = 5; wr_en_mem = 1; result_mem = 10;
    rw_wb = 5; wr_en_wb = 1; result_wb = 20; extended_ex = 3; opb_selector_ex = 1;
    rw_ex = 7; wr_en_ex = 1;
    send(1, 32'd13);
    ra_ex = 0; rda_ex = 0;
    send(1, 32'd3);
    ra_ex = 5; rda_ex = 1; wr_en_mem = 0;
    send(1, 32'd23);

    // Modulo 100 mod 7 with forwarding noise while busy
    clr_inputs();
    valid_in = 1; alu_func_ex = 1; ra_ex = 1; rda_ex = 100; opb_selector_ex = 1;
    extended_ex = 7; rw_ex = 3; wr_en_ex = 1; rb_ex = 2; rdb_ex = 32'hABCD;
    send(1, 32'd2);

    // Wide operands through the rdb path
    opb_selector_ex = 0; wr_en_mem = 0; wr_en_wb = 0;
    rda_ex = 32'hFFFF_FFFF; rdb_ex = 32'h0001_0001;
    send(1, 32'd0);
    wr_en_mem = 0; wr_en_wb = 0;
    rda_ex = 32'd123456789; rdb_ex = 32'd1000;
    send(1, 32'd789);
    wr_en_mem = 0; wr_en_wb = 0;
    rda_ex = 32'd5; rdb_ex = 32'd9;
    send(1, 32'd5);

    // Divide by zero, then an add clears div_zero
    wr_en_mem = 0; wr_en_wb = 0;
    rda_ex = 32'd42; rdb_ex = 32'd0;
    send(1, 32'd42);
    alu_func_ex = 0; rdb_ex = 32'd8;
    send(1, 32'd50);

    // Reset during BUSY cycle 10 aborts the modulo
    clr_inputs();
    valid_in = 1; alu_func_ex = 1; rda_ex = 32'd1000; opb_selector_ex = 1; extended_ex = 32'd7;
    wr_en_ex = 1; rw_ex = 4;
    repeat (10) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    clr_inputs();
    #1;
    chk("abort_valid_out", N'(valid_out), '0);
    chk("abort_alu_result", alu_result, '0);
    chk("abort_store_data", store_data, '0);
    chk("abort_rw_out", N'(rw_out), '0);
    chk("abort_wr_en_out", N'(wr_en_out), '0);
    chk("abort_stall", N'(stall), '0);
    valid_in = 1; rda_ex = 32'd11; extended_ex = 32'd4; opb_selector_ex = 1; rw_ex = 9; wr_en_ex = 1;
    send(1, 32'd15);

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      valid_in = ($urandom_range(0, 9) != 0);
      ra_ex = 5'($urandom_range(0, 7)); rb_ex = 5'($urandom_range(0, 7));
      rw_ex = 5'($urandom_range(0, 31));
      rda_ex = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
      rdb_ex = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
      extended_ex = $urandom_range(0, 40);
      opb_selector_ex = 1'($urandom); alu_func_ex = 1'($urandom);
      wr_en_ex = 1'($urandom); wd_selector_ex = 1'($urandom); wm_ex = 1'($urandom);
      scramble_fwd();
      send(0, '0);
    end

    clr_inputs();
    for (int w = 0; w < 100 && q.size() != 0; w++) @(posedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
